// File: rtl/can_stuff_pkg.sv
// Shared stuffing definitions: stuffing mode encoding and default CAN / CAN FD constants.
package can_stuff_pkg;

   typedef enum logic {
      STUFF_DYNAMIC = 1'b0,
      STUFF_FIXED   = 1'b1
   } stuff_mode_t;

   localparam int CAN_RUN_LEN           = 5;
   localparam int CAN_FD_FIXED_INTERVAL = 4;

endpackage

// File: rtl/bit_destuff_unit.sv
// Receive-side bit destuffer: removes dynamic (run-length) and fixed-interval stuff bits,
// forwarding data bits and flagging stuff-rule violations. All outputs are registered.
module bit_destuff_unit
   import can_stuff_pkg::*;
#(
   parameter int RUN_LEN        = CAN_RUN_LEN,
   parameter int FIXED_INTERVAL = CAN_FD_FIXED_INTERVAL,
   parameter int CNT_W          = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             sample_point,
   input  logic             rx_bit,
   input  logic             stuffing_active,
   input  logic             mode,
   input  logic             restart,
   output logic             data_valid,
   output logic             data_bit,
   output logic             stuff_bit_seen,
   output logic             stuff_error,
   output logic             error_latched,
   output logic [CNT_W-1:0] stuff_count
);

   localparam logic [3:0] RUN_LEN_4  = 4'(RUN_LEN);
   localparam logic [3:0] FIXED_IV_4 = 4'(FIXED_INTERVAL);

   logic [3:0]       run_count_reg, run_count_next;
   logic [3:0]       fx_cnt_reg, fx_cnt_next;
   logic             last_bit_reg, last_bit_next;
   logic             mode_prev_reg, mode_prev_next;
   logic [CNT_W-1:0] stuff_count_reg, stuff_count_next;
   logic             error_latched_reg, error_latched_next;
   logic             data_valid_reg, data_valid_next;
   logic             data_bit_reg, data_bit_next;
   logic             stuff_bit_seen_reg, stuff_bit_seen_next;
   logic             stuff_error_reg, stuff_error_next;

   stuff_mode_t      mode_cur;
   logic             mode_rise;
   logic [3:0]       fx_eff;

   assign mode_cur  = stuff_mode_t'(mode);
   assign mode_rise = (mode_cur == STUFF_FIXED) && !mode_prev_reg && stuffing_active;
   // A bit sampled in the very cycle fixed mode starts must already be seen as a stuff bit.
   assign fx_eff    = mode_rise ? FIXED_IV_4 : fx_cnt_reg;

   always_comb begin
      run_count_next      = run_count_reg;
      fx_cnt_next         = fx_cnt_reg;
      last_bit_next       = last_bit_reg;
      mode_prev_next      = mode;
      stuff_count_next    = stuff_count_reg;
      error_latched_next  = error_latched_reg;
      data_valid_next     = 1'b0;
      data_bit_next       = data_bit_reg;
      stuff_bit_seen_next = 1'b0;
      stuff_error_next    = 1'b0;

      if (restart) begin
         run_count_next     = 4'd0;
         fx_cnt_next        = 4'd0;
         last_bit_next      = 1'b1;
         stuff_count_next   = '0;
         error_latched_next = 1'b0;
      end else if (!stuffing_active) begin
         run_count_next = 4'd0;
         last_bit_next  = 1'b1;
         if (sample_point) begin
            data_valid_next = 1'b1;
            data_bit_next   = rx_bit;
         end
      end else begin
         fx_cnt_next = fx_eff;
         if (sample_point) begin
            last_bit_next = rx_bit;
            if (mode_cur == STUFF_FIXED) begin
               if (fx_eff == FIXED_IV_4) begin
                  fx_cnt_next = 4'd0;
                  if (rx_bit == !last_bit_reg) begin
                     stuff_bit_seen_next = 1'b1;
                  end else begin
                     stuff_error_next   = 1'b1;
                     error_latched_next = 1'b1;
                  end
               end else begin
                  data_valid_next = 1'b1;
                  data_bit_next   = rx_bit;
                  fx_cnt_next     = fx_eff + 4'd1;
               end
            end else begin
               if (run_count_reg == RUN_LEN_4) begin
                  run_count_next = 4'd1;
                  if (rx_bit != last_bit_reg) begin
                     stuff_bit_seen_next = 1'b1;
                     stuff_count_next    = stuff_count_reg + CNT_W'(1);
                  end else begin
                     stuff_error_next   = 1'b1;
                     error_latched_next = 1'b1;
                  end
               end else begin
                  data_valid_next = 1'b1;
                  data_bit_next   = rx_bit;
                  run_count_next  = (rx_bit == last_bit_reg) ? run_count_reg + 4'd1 : 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         run_count_reg      <= 4'd0;
         fx_cnt_reg         <= 4'd0;
         last_bit_reg       <= 1'b1;
         mode_prev_reg      <= mode;
         stuff_count_reg    <= '0;
         error_latched_reg  <= 1'b0;
         data_valid_reg     <= 1'b0;
         data_bit_reg       <= 1'b1;
         stuff_bit_seen_reg <= 1'b0;
         stuff_error_reg    <= 1'b0;
      end else begin
         run_count_reg      <= run_count_next;
         fx_cnt_reg         <= fx_cnt_next;
         last_bit_reg       <= last_bit_next;
         mode_prev_reg      <= mode_prev_next;
         stuff_count_reg    <= stuff_count_next;
         error_latched_reg  <= error_latched_next;
         data_valid_reg     <= data_valid_next;
         data_bit_reg       <= data_bit_next;
         stuff_bit_seen_reg <= stuff_bit_seen_next;
         stuff_error_reg    <= stuff_error_next;
      end
   end

   assign data_valid     = data_valid_reg;
   assign data_bit       = data_bit_reg;
   assign stuff_bit_seen = stuff_bit_seen_reg;
   assign stuff_error    = stuff_error_reg;
   assign error_latched  = error_latched_reg;
   assign stuff_count    = stuff_count_reg;

endmodule

// File: tb/tb_bit_destuff_unit.sv
// Directed self-checking bench for bit_destuff_unit with hand-computed expectations.
module tb_bit_destuff_unit;

   localparam int CNT_W = 3;
   localparam logic [2:0] K_NONE = 3'b000;
   localparam logic [2:0] K_DATA = 3'b100;
   localparam logic [2:0] K_STUF = 3'b010;
   localparam logic [2:0] K_ERR  = 3'b001;

   logic             clock = 1'b0;
   logic             reset, enable, sample_point, rx_bit, stuffing_active, mode, restart;
   logic             data_valid, data_bit, stuff_bit_seen, stuff_error, error_latched;
   logic [CNT_W-1:0] stuff_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   bit_destuff_unit #(.RUN_LEN(5), .FIXED_INTERVAL(4), .CNT_W(CNT_W)) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .sample_point    (sample_point),
      .rx_bit          (rx_bit),
      .stuffing_active (stuffing_active),
      .mode            (mode),
      .restart         (restart),
      .data_valid      (data_valid),
      .data_bit        (data_bit),
      .stuff_bit_seen  (stuff_bit_seen),
      .stuff_error     (stuff_error),
      .error_latched   (error_latched),
      .stuff_count     (stuff_count)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total_cnt++;
      if (obs === exp_v) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One sample_point cycle; any control set by the caller beforehand stays applied.
   task automatic send(input logic b, input logic [2:0] kind, input string tag);
      @(negedge clock);
      sample_point = 1'b1;
      rx_bit       = b;
      @(posedge clock);
      #1;
      sample_point = 1'b0;
      check_val(tag, {5'd0, data_valid, stuff_bit_seen, stuff_error}, {5'd0, kind});
      if (kind == K_DATA) check_val({tag, "_bit"}, {7'd0, data_bit}, {7'd0, b});
      $display("bit=%0b dv=%0b sbs=%0b se=%0b el=%0b cnt=%0d  [%s]",
               b, data_valid, stuff_bit_seen, stuff_error, error_latched, stuff_count, tag);
   endtask

   task automatic idle();
      @(negedge clock);
      @(posedge clock);
      #1;
   endtask

   task automatic do_restart();
      @(negedge clock);
      restart = 1'b1;
      idle();
      restart = 1'b0;
   endtask

   logic v;

   initial begin
      reset = 1'b1; enable = 1'b1; sample_point = 1'b0; rx_bit = 1'b1;
      stuffing_active = 1'b1; mode = 1'b0; restart = 1'b0;
      idle(); idle();
      check_val("rst_pulses", {5'd0, data_valid, stuff_bit_seen, stuff_error}, 8'd0);
      check_val("rst_el", {7'd0, error_latched}, 8'd0);
      check_val("rst_dbit", {7'd0, data_bit}, 8'd1);
      check_val("rst_cnt", {5'd0, stuff_count}, 8'd0);
      @(negedge clock); reset = 1'b0;
      idle();
      check_val("idle_pulses", {5'd0, data_valid, stuff_bit_seen, stuff_error}, 8'd0);

      // Five zeros then a complementary stuff bit
      for (int i = 0; i < 5; i++) send(1'b0, K_DATA, "dyn0_data");
      send(1'b1, K_STUF, "dyn0_stuff");
      check_val("dyn0_cnt", {5'd0, stuff_count}, 8'd1);

      // Six ones: sixth violates the rule
      do_restart();
      for (int i = 0; i < 5; i++) send(1'b1, K_DATA, "dyn1_data");
      send(1'b1, K_ERR, "dyn1_err");
      check_val("dyn1_el", {7'd0, error_latched}, 8'd1);
      send(1'b0, K_DATA, "dyn1_after");
      check_val("dyn1_el_hold", {7'd0, error_latched}, 8'd1);
      do_restart();
      check_val("dyn1_el_clr", {7'd0, error_latched}, 8'd0);

      // Nine stuff events: counter wraps 7 -> 0 -> 1
      for (int i = 0; i < 5; i++) send(1'b0, K_DATA, "wrap_data");
      send(1'b1, K_STUF, "wrap_stuff");
      v = 1'b1;
      for (int e = 2; e <= 9; e++) begin
         for (int i = 0; i < 4; i++) send(v, K_DATA, "wrap_data");
         send(!v, K_STUF, "wrap_stuff");
         v = !v;
         check_val("wrap_cnt", {5'd0, stuff_count}, 8'(e % 8));
      end

      // Fixed mode after last_bit=0: stuff, four data, stuff
      do_restart();
      send(1'b0, K_DATA, "fx_pre");
      @(negedge clock); mode = 1'b1;
      idle();
      send(1'b1, K_STUF, "fx_stuff0");
      send(1'b1, K_DATA, "fx_data");
      send(1'b0, K_DATA, "fx_data");
      send(1'b1, K_DATA, "fx_data");
      send(1'b0, K_DATA, "fx_data");
      send(1'b1, K_STUF, "fx_stuff1");
      check_val("fx_cnt_hold", {5'd0, stuff_count}, 8'd0);
      check_val("fx_el", {7'd0, error_latched}, 8'd0);

      // Same start but first fixed bit equals last_bit
      @(negedge clock); mode = 1'b0;
      idle();
      send(1'b0, K_DATA, "fx2_pre");
      @(negedge clock); mode = 1'b1;
      idle();
      send(1'b0, K_ERR, "fx2_err");
      check_val("fx2_el", {7'd0, error_latched}, 8'd1);
      @(negedge clock); mode = 1'b0;
      do_restart();

      // Reset mid-run discards the run; sample during reset is dropped
      for (int i = 0; i < 3; i++) send(1'b0, K_DATA, "rst_mid_data");
      reset = 1'b1;
      send(1'b0, K_NONE, "rst_mid_drop");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) send(1'b0, K_DATA, "rst_post_data");
      send(1'b1, K_STUF, "rst_post_stuff");
      check_val("rst_post_cnt", {5'd0, stuff_count}, 8'd1);

      // Restart together with a sample point
      for (int i = 0; i < 4; i++) send(1'b1, K_DATA, "rs_data");
      send(1'b1, K_ERR, "rs_err");
      restart = 1'b1;
      send(1'b0, K_NONE, "rs_drop");
      restart = 1'b0;
      check_val("rs_el", {7'd0, error_latched}, 8'd0);
      check_val("rs_cnt", {5'd0, stuff_count}, 8'd0);

      // enable low behaves as reset
      send(1'b0, K_DATA, "en_pre");
      send(1'b0, K_DATA, "en_pre");
      enable = 1'b0;
      send(1'b0, K_NONE, "en_drop");
      check_val("en_dbit", {7'd0, data_bit}, 8'd1);
      enable = 1'b1;

      // Inactive region forwards everything, then run starts fresh
      @(negedge clock); stuffing_active = 1'b0;
      for (int i = 0; i < 7; i++) send(1'b0, K_DATA, "inact_data");
      send(1'b1, K_DATA, "inact_data");
      @(negedge clock); stuffing_active = 1'b1;
      idle();
      for (int i = 0; i < 5; i++) send(1'b0, K_DATA, "act_data");
      send(1'b0, K_ERR, "act_err");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
